branch_predictor: RTL and testbench

Next-PC predictor for the IF stage of the pipelined RV32I core. It consumes the BTB tag/target storage and a pattern history table of 2-bit saturating counters, and produces a predicted next PC every cycle. Branch outcomes resolved in EX are written back through a single update port. Prediction is combinational on `if_pc`; all state changes occur at `posedge clk`.

---
 rtl/branch_predictor_pkg.sv | 20 ++
 rtl/branch_predictor_pattern_history_table.sv | 32 +++
 rtl/branch_predictor.sv | 83 ++++++++
 tb/tb_branch_predictor.sv | 138 +++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: shared BTB/PHT sizing, counter encodings and saturating counter step
package branch_predictor_pkg;

    localparam int BTB_INDEX_WIDTH = 5;
    localparam int TAG_WIDTH       = 32 - BTB_INDEX_WIDTH - 2;
    localparam int BTB_ENTRIES     = 1 << BTB_INDEX_WIDTH;

    typedef enum logic [1:0] {
        CNT_SNT = 2'b00,
        CNT_WNT = 2'b01,
        CNT_WT  = 2'b10,
        CNT_ST  = 2'b11
    } cnt_e;

    function automatic cnt_e cnt_next(cnt_e c, logic taken);
        return taken ? (c == CNT_ST  ? CNT_ST  : cnt_e'(c + 2'd1))
                     : (c == CNT_SNT ? CNT_SNT : cnt_e'(c - 2'd1));
    endfunction

endpackage

// File: rtl/branch_predictor_pattern_history_table.sv
// pattern_history_table: 2-bit saturating counters, combinational read, one saturating write per cycle
module pattern_history_table
    import branch_predictor_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic [BTB_INDEX_WIDTH-1:0] rd_index,
    output logic [1:0]                 rd_cnt,
    input  logic                       wr_en,
    input  logic [BTB_INDEX_WIDTH-1:0] wr_index,
    input  logic                       wr_taken
);

    cnt_e cnt_q [BTB_ENTRIES];
    cnt_e cnt_d [BTB_ENTRIES];

    always_comb begin
        cnt_d = cnt_q;
        if (wr_en) cnt_d[wr_index] = cnt_next(cnt_q[wr_index], wr_taken);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BTB_ENTRIES; i++) cnt_q[i] <= CNT_WNT;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign rd_cnt = cnt_q[rd_index];

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: BTB + PHT next-PC predictor; define BRANCH_PREDICTOR_GSHARE_EN to XOR a GHR into the PHT index
module branch_predictor
    import branch_predictor_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic [31:0]                if_pc,
    output logic [31:0]                predicted_pc,
    output logic                       predicted_taken,
    output logic [BTB_INDEX_WIDTH-1:0] pred_pht_index,
    input  logic                       update_valid,
    input  logic [31:0]                update_pc,
    input  logic [31:0]                update_target,
    input  logic                       update_taken,
    input  logic [BTB_INDEX_WIDTH-1:0] update_pht_index
);

    logic [BTB_ENTRIES-1:0]     valid_q, valid_d;
    logic [TAG_WIDTH-1:0]       tag_q [BTB_ENTRIES];
    logic [TAG_WIDTH-1:0]       tag_d [BTB_ENTRIES];
    logic [31:0]                target_q [BTB_ENTRIES];
    logic [31:0]                target_d [BTB_ENTRIES];
    logic [BTB_INDEX_WIDTH-1:0] if_idx, up_idx;
    logic [TAG_WIDTH-1:0]       if_tag, up_tag;
    logic [1:0]                 pht_cnt;
    logic                       hit, btb_wr;
    logic                       unused_pc_bits;

    assign if_idx = if_pc[BTB_INDEX_WIDTH+1:2];
    assign if_tag = if_pc[31:BTB_INDEX_WIDTH+2];
    assign up_idx = update_pc[BTB_INDEX_WIDTH+1:2];
    assign up_tag = update_pc[31:BTB_INDEX_WIDTH+2];
    assign unused_pc_bits = ^{if_pc[1:0], update_pc[1:0]};

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [BTB_INDEX_WIDTH-1:0] ghr_q, ghr_d;

    // History advances only on resolved outcomes, so no speculative repair is needed
    always_comb ghr_d = update_valid ? {ghr_q[BTB_INDEX_WIDTH-2:0], update_taken} : ghr_q;

    always_ff @(posedge clk) ghr_q <= reset ? '0 : ghr_d;

    assign pred_pht_index = if_idx ^ ghr_q;
`else
    assign pred_pht_index = if_idx;
`endif

    pattern_history_table u_pht (
        .clk      (clk),
        .reset    (reset),
        .rd_index (pred_pht_index),
        .rd_cnt   (pht_cnt),
        .wr_en    (update_valid),
        .wr_index (update_pht_index),
        .wr_taken (update_taken)
    );

    // Only taken outcomes allocate; not-taken never touches the BTB
    assign btb_wr = update_valid && update_taken;

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (btb_wr) begin
            valid_d[up_idx]  = 1'b1;
            tag_d[up_idx]    = up_tag;
            target_d[up_idx] = update_target;
        end
    end

    always_ff @(posedge clk) valid_q <= reset ? '0 : valid_d;

    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

    assign hit             = valid_q[if_idx] && tag_q[if_idx] == if_tag;
    assign predicted_taken = hit && pht_cnt[1];
    assign predicted_pc    = predicted_taken ? target_q[if_idx] : if_pc + 32'd4;

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed vectors with hand-computed expectations for branch_predictor
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_pc;
    logic [31:0] predicted_pc;
    logic        predicted_taken;
    logic [4:0]  pred_pht_index;
    logic        update_valid;
    logic [31:0] update_pc;
    logic [31:0] update_target;
    logic        update_taken;
    logic [4:0]  update_pht_index;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk              (clk),
        .reset            (reset),
        .if_pc            (if_pc),
        .predicted_pc     (predicted_pc),
        .predicted_taken  (predicted_taken),
        .pred_pht_index   (pred_pht_index),
        .update_valid     (update_valid),
        .update_pc        (update_pc),
        .update_target    (update_target),
        .update_taken     (update_taken),
        .update_pht_index (update_pht_index)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_update(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                              input logic tk, input logic [4:0] idx);
        update_valid     = v;
        update_pc        = pc;
        update_target    = tgt;
        update_taken     = tk;
        update_pht_index = idx;
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk, input logic [4:0] idx);
        @(negedge clk);
        set_update(1'b1, pc, tgt, tk, idx);
        @(negedge clk);
        update_valid = 1'b0;
    endtask

    task automatic predict(input string tag, input logic [31:0] pc, input logic exp_tk,
                           input logic [31:0] exp_pc, input logic [4:0] exp_idx);
        if_pc = pc;
        #1;
        check({tag, "_taken"}, {31'd0, predicted_taken}, {31'd0, exp_tk});
        check({tag, "_pc"}, predicted_pc, exp_pc);
        check({tag, "_idx"}, {27'd0, pred_pht_index}, {27'd0, exp_idx});
    endtask

    initial begin
        reset = 1'b1;
        if_pc = 32'h100;
        set_update(1'b0, 32'h0, 32'h0, 1'b0, 5'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        predict("reset", 32'h100, 1'b0, 32'h104, 5'd0);

`ifndef BRANCH_PREDICTOR_GSHARE_EN
        // Same-cycle read sees the old state, then the allocation lands
        @(negedge clk);
        set_update(1'b1, 32'h100, 32'h200, 1'b1, 5'd0);
        predict("same_cycle", 32'h100, 1'b0, 32'h104, 5'd0);
        @(negedge clk);
        update_valid = 1'b0;
        predict("allocate", 32'h100, 1'b1, 32'h200, 5'd0);
        predict("tag_miss", 32'h180, 1'b0, 32'h184, 5'd0);
        predict("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0, 5'd31);

        // Counter 10 -> saturates at 11, then walks down
        for (int i = 0; i < 4; i++) upd(32'h100, 32'h200, 1'b1, 5'd0);
        upd(32'h100, 32'h200, 1'b0, 5'd0);
        predict("sat_hi_nt1", 32'h100, 1'b1, 32'h200, 5'd0);
        upd(32'h100, 32'h200, 1'b0, 5'd0);
        predict("sat_hi_nt2", 32'h100, 1'b0, 32'h104, 5'd0);
        upd(32'h100, 32'h200, 1'b0, 5'd0);
        upd(32'h100, 32'h200, 1'b0, 5'd0);
        upd(32'h100, 32'h200, 1'b1, 5'd0);
        predict("sat_lo_t1", 32'h100, 1'b0, 32'h104, 5'd0);
        upd(32'h100, 32'h200, 1'b1, 5'd0);
        predict("sat_lo_t2", 32'h100, 1'b1, 32'h200, 5'd0);

        upd(32'h104, 32'h300, 1'b1, 5'd1);
        predict("idx1", 32'h104, 1'b1, 32'h300, 5'd1);
        predict("idx0_kept", 32'h100, 1'b1, 32'h200, 5'd0);

        // Not-taken update at index 2 must neither replace nor invalidate the entry
        upd(32'h188, 32'h400, 1'b1, 5'd2);
        upd(32'h108, 32'h500, 1'b0, 5'd5);
        predict("nt_keep", 32'h188, 1'b1, 32'h400, 5'd2);
        predict("nt_noalloc", 32'h108, 1'b0, 32'h10C, 5'd2);

        @(negedge clk);
        reset = 1'b1;
        set_update(1'b1, 32'h100, 32'h200, 1'b1, 5'd0);
        @(negedge clk);
        reset = 1'b0;
        update_valid = 1'b0;
        predict("prio_0", 32'h100, 1'b0, 32'h104, 5'd0);
        predict("prio_1", 32'h104, 1'b0, 32'h108, 5'd1);
        upd(32'h100, 32'h200, 1'b1, 5'd0);
        predict("post_reset", 32'h100, 1'b1, 32'h200, 5'd0);
`else
        for (int i = 0; i < 3; i++) upd(32'h100, 32'h200, 1'b1, 5'd0);
        predict("gshare_0", 32'h100, 1'b0, 32'h104, 5'd7);
        predict("gshare_1", 32'h104, 1'b0, 32'h108, 5'd6);
        upd(32'h104, 32'h300, 1'b0, 5'd6);
        predict("gshare_nt", 32'h100, 1'b0, 32'h104, 5'd14);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        predict("gshare_rst", 32'h100, 1'b0, 32'h104, 5'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
